// File: rtl/bcd_pkg.sv
// Constants, state encoding and helpers shared by the binary<->BCD conversion blocks.
package bcd_pkg;

  localparam int         BCD_NIBBLE_W = 4;
  localparam logic [3:0] ADD3_THRESH  = 4'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_nibble
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] nib_i,
  output logic [BCD_NIBBLE_W-1:0] nib_o
);

  // Inputs never exceed 9, so the corrected value stays within 12 and fits in 4 bits.
  always_comb begin
    nib_o = nib_i;
    if (nib_i >= ADD3_THRESH) nib_o = nib_i + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// with a start/busy/done handshake and an overflow flag for too few digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [BIN_W-1:0]               bin_in,
  output logic                           busy,
  output logic                           done,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_out,
  output logic                           overflow
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (clog2(BIN_W) < 1) ? 1 : clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t            state_q;
  logic [SR_W-1:0]   sr_q;
  logic [SR_W-1:0]   sr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_acc_q;
  logic              busy_q;
  logic              done_q;
  logic [BCD_W-1:0]  bcd_out_q;
  logic              overflow_q;

  logic [BCD_W-1:0]  bcd_corr;
  logic              shift_out;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .nib_i (sr_q[BIN_W + BCD_NIBBLE_W*k +: BCD_NIBBLE_W]),
      .nib_o (bcd_corr[BCD_NIBBLE_W*k +: BCD_NIBBLE_W])
    );
  end

  // Corrected BCD field and untouched binary field shifted left together;
  // the MSB of the corrected field is the digit carry that falls off the top.
  assign shift_out = bcd_corr[BCD_W-1];
  assign sr_d      = {bcd_corr[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_out_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q      <= {{BCD_W{1'b0}}, bin_in};
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q      <= sr_d;
          cnt_q     <= cnt_q + 1'b1;
          ovf_acc_q <= ovf_acc_q | shift_out;
          // Results are loaded on the final shift so they and done are
          // already visible throughout the FINISH cycle.
          if (cnt_q == CNT_LAST) begin
            state_q    <= FINISH;
            done_q     <= 1'b1;
            bcd_out_q  <= sr_d[SR_W-1 -: BCD_W];
            overflow_q <= ovf_acc_q | shift_out;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: a 3-digit and a 2-digit converter driven in lockstep,
// results checked against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [7:0]  bin_in = '0;

  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy3),
    .done     (done3),
    .bcd_out  (bcd3),
    .overflow (ovf3)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy2),
    .done     (done2),
    .bcd_out  (bcd2),
    .overflow (ovf2)
  );

  function automatic logic [31:0] ref_bcd(input int v, input int digits);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < digits; k++) begin
      r = r | (32'((v / p) % 10) << (4 * k));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_ovf(input int v, input int digits);
    int p;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    return (v >= p) ? 32'd1 : 32'd0;
  endfunction

  function automatic int bcd_value(input logic [31:0] b, input int digits);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int k = 0; k < digits; k++) begin
      r = r + int'((b >> (4 * k)) & 32'hF) * p;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input int v, input string tag);
    int lat;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'(v);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check({tag, " busy"}, 32'(busy3), 32'd1);
    while (!done3 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " bcd3"}, 32'(bcd3), ref_bcd(v, 3));
    check({tag, " ovf3"}, 32'(ovf3), ref_ovf(v, 3));
    check({tag, " done2"}, 32'(done2), 32'd1);
    check({tag, " bcd2"}, 32'(bcd2), ref_bcd(v, 2));
    check({tag, " ovf2"}, 32'(ovf2), ref_ovf(v, 2));
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done3), 32'd0);
  endtask

  initial begin
    int seen;
    int gap;
    int ndone;
    logic [31:0] got;
    int dir_vals[6];

    // Reset, then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst busy", 32'(busy3), 32'd0);
    check("rst done", 32'(done3), 32'd0);
    check("rst bcd", 32'(bcd3), 32'd0);
    check("rst ovf", 32'(ovf3), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done3 || done2 || busy3) seen++;
    end
    check("idle quiet", 32'(seen), 32'd0);

    // Directed single conversions
    dir_vals = '{0, 9, 10, 99, 128, 255};
    foreach (dir_vals[i]) run_conv(dir_vals[i], $sformatf("dir%0d", dir_vals[i]));

    // Exhaustive, start held high
    @(negedge clk);
    bin_in = 8'd0;
    start  = 1'b1;
    for (int v = 0; v < 256; v++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done3 && gap < 20);
      check($sformatf("exh%0d gap", v), 32'(gap), (v == 0) ? 32'd9 : 32'd10);
      check($sformatf("exh%0d bcd3", v), 32'(bcd3), ref_bcd(v, 3));
      check($sformatf("exh%0d ovf3", v), 32'(ovf3), ref_ovf(v, 3));
      check($sformatf("exh%0d bcd2", v), 32'(bcd2), ref_bcd(v, 2));
      check($sformatf("exh%0d ovf2", v), 32'(ovf2), ref_ovf(v, 2));
      if (v < 16) check($sformatf("rt%0d", v), 32'(bcd_value(32'(bcd3), 3)), 32'(v));
      if (v == 255) start = 1'b0;
      else bin_in = 8'(v + 1);
    end
    @(negedge clk);
    check("exh end done", 32'(done3), 32'd0);
    repeat (3) @(negedge clk);
    check("exh end idle", 32'(busy3), 32'd0);

    // Start while busy is ignored
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    bin_in = 8'd55;
    ndone  = 0;
    got    = '0;
    for (int c = 1; c <= 25; c++) begin
      if (done3) begin
        ndone++;
        got = 32'(bcd3);
      end
      start = (c == 2 || c == 5);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy ign count", 32'(ndone), 32'd1);
    check("busy ign value", got, 32'h200);
    run_conv(55, "after busy");

    // Overflow on the 2-digit instance
    run_conv(123, "ovf123");
    run_conv(99, "ovf99");

    // Randomized
    repeat (40) run_conv(int'($urandom_range(0, 255)), "rand");

    // Async reset mid-conversion
    run_conv(200, "pre rst");
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy3), 32'd0);
    check("arst done", 32'(done3), 32'd0);
    check("arst bcd3", 32'(bcd3), 32'd0);
    check("arst ovf2", 32'(ovf2), 32'd0);
    check("arst bcd2", 32'(bcd2), 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done3 || busy3) seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done3 || done2 || busy3) seen++;
    end
    check("arst no done", 32'(seen), 32'd0);
    run_conv(77, "post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
